// File: rtl/fmeas_multi.sv
`default_nettype none
// ============================================================================
// Module      : fmeas_multi
// Description : Multi-channel reciprocal frequency meter. One of N_CH
//               asynchronous waveforms is selected at start. The block counts
//               whole wave periods (ca) and their total length in clk cycles
//               (cb) over a gate that opens and closes on rising wave edges.
//               Optional feature macro: FMEAS_TIMEOUT_EN. When it is defined,
//               an edge-wait watchdog aborts measurements that see no edges.
// Revision    : 1.0 - initial release
// ============================================================================
module fmeas_multi #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 32,
    parameter int GATE_W         = 24,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_CH-1:0]                            wave,
    input  logic                                       start,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    input  logic [GATE_W-1:0]                          gate_cycles,
    output logic                                       busy,
    output logic                                       done,
    output logic [CNT_W-1:0]                           ca,
    output logic [CNT_W-1:0]                           cb,
    output logic                                       ovf,
    output logic                                       timeout
);

    localparam int               c_CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [c_CH_W:0]  c_N_CH    = (c_CH_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [GATE_W-1:0] c_GATE_ONE = GATE_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARM   = 2'd1;
    localparam logic [1:0] c_ST_GATE  = 2'd2;
    localparam logic [1:0] c_ST_CLOSE = 2'd3;

    // Reject configurations outside the supported range at elaboration.
    if (N_CH < 1 || N_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fmeas_multi: N_CH must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    logic [N_CH-1:0]   r_sync1;
    logic [N_CH-1:0]   r_sync2;
    logic [N_CH-1:0]   r_hist;
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [c_CH_W-1:0] r_ch;
    logic [GATE_W-1:0] r_gate_len;
    logic [GATE_W-1:0] r_timer;
    logic [CNT_W-1:0]  r_ea;
    logic [CNT_W-1:0]  r_eb;
    logic [CNT_W-1:0]  w_ea_inc;
    logic [CNT_W-1:0]  w_eb_inc;
    logic              w_ea_sat;
    logic              w_eb_sat;
    logic              w_sel_now;
    logic              w_sel_prev;
    logic              w_e;
    logic              w_accept;
    logic              w_open;
    logic              w_close;
    logic              w_abort;
    logic              w_counting;
    logic              w_wait_hit;

    // Two-flop synchroniser plus history flop on every wave input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= wave;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Pick the latched channel out of the synchronised vectors.
    always_comb begin
        w_sel_now  = 1'b0;
        w_sel_prev = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch == c_CH_W'(i)) begin
                w_sel_now  = r_sync2[i];
                w_sel_prev = r_hist[i];
            end
        end
    end

    assign w_e        = w_sel_now & ~w_sel_prev;
    assign w_counting = (r_state == c_ST_GATE) || (r_state == c_ST_CLOSE);

    // Saturating increments: hold at all-ones instead of wrapping.
    assign w_ea_sat = (r_ea == c_CNT_MAX);
    assign w_eb_sat = (r_eb == c_CNT_MAX);
    assign w_ea_inc = w_ea_sat ? r_ea : (r_ea + c_CNT_ONE);
    assign w_eb_inc = w_eb_sat ? r_eb : (r_eb + c_CNT_ONE);

`ifdef FMEAS_TIMEOUT_EN
    localparam int                c_WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    logic [c_WAIT_W-1:0] r_wait;

    // Edge-wait watchdog: restarts on every edge, runs while waiting for one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_accept || w_e) begin
            r_wait <= '0;
        end else if ((r_state == c_ST_ARM) || (r_state == c_ST_CLOSE)) begin
            r_wait <= r_wait + c_WAIT_ONE;
        end
    end

    assign w_wait_hit = ((r_state == c_ST_ARM) || (r_state == c_ST_CLOSE)) &&
                        (r_wait == c_WAIT_LAST);

    // Timeout flag: cleared by an accepted start, set by a watchdog abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (w_accept) begin
            timeout <= 1'b0;
        end else if (w_abort) begin
            timeout <= 1'b1;
        end
    end
`else
    assign w_wait_hit = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode. done is registered, so the cycle it is
    // high is already IDLE; a start in that cycle is rejected by gating on it.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_open       = 1'b0;
        w_close      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !done) begin
                    w_accept     = 1'b1;
                    w_next_state = c_ST_ARM;
                end
            end
            c_ST_ARM: begin
                if (w_e) begin
                    w_open       = 1'b1;
                    w_next_state = c_ST_GATE;
                end else if (w_wait_hit) begin
                    w_abort      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_GATE: begin
                if (r_timer == c_GATE_ONE) begin
                    if (w_e) begin
                        w_close      = 1'b1;
                        w_next_state = c_ST_IDLE;
                    end else begin
                        w_next_state = c_ST_CLOSE;
                    end
                end
            end
            c_ST_CLOSE: begin
                if (w_e) begin
                    w_close      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (w_wait_hit) begin
                    w_abort      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Measurement datapath: latch request, run counters, publish results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            ca         <= '0;
            cb         <= '0;
            ovf        <= 1'b0;
            r_ch       <= '0;
            r_gate_len <= '0;
            r_timer    <= '0;
            r_ea       <= '0;
            r_eb       <= '0;
        end else begin
            busy <= (w_next_state != c_ST_IDLE);
            done <= w_close | w_abort;

            if (w_accept) begin
                r_ch       <= ({1'b0, ch_sel} >= c_N_CH) ? '0 : ch_sel;
                r_gate_len <= (gate_cycles == '0) ? c_GATE_ONE : gate_cycles;
                ovf        <= 1'b0;
            end

            if (w_open) begin
                r_ea    <= '0;
                r_eb    <= '0;
                r_timer <= r_gate_len;
            end else if (w_counting) begin
                r_eb <= w_eb_inc;
                if (w_e) begin
                    r_ea <= w_ea_inc;
                end
                if (w_eb_sat || (w_e && w_ea_sat)) begin
                    ovf <= 1'b1;
                end
                if (r_state == c_ST_GATE) begin
                    r_timer <= r_timer - c_GATE_ONE;
                end
            end

            // The closing edge itself is one more period and one more cycle.
            if (w_close) begin
                ca <= w_ea_inc;
                cb <= w_eb_inc;
            end else if (w_abort) begin
                ca <= '0;
                cb <= '0;
            end
        end
    end

endmodule
`default_nettype wire
